ibex_rvfi_unpacker: RTL and testbench
=====================================

# ibex_rvfi_unpacker

Receive-side counterpart of the instruction-trace path. It accepts a serialised stream of packed retirement records over a 32-bit valid/ready word interface, for example from a trace FIFO, a replay file reader or an off-chip trace link. It reconstructs one RVFI retirement per record on the standard `rvfi_*` signal set, so `ibex_tracer`, checkers and co-simulation monitors can run against captured traces without a live core.

## Interface
Parameters:
- `OrderInit`, 64'd0: `rvfi_order` value given to the first emitted record after reset.
- `StrictHeader`, 1'b1: when 1, nonzero reserved header bits drop the record and set `err_o`; when 0, reserved bits are ignored.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - `clk_i` in 1: clock.
  - `rst_i` in 1: synchronous reset, active-high.
- Input word stream:
  - `in_valid_i` in 1: word valid.
  - `in_ready_o` out 1: word accepted when `in_valid_i & in_ready_o`.
  - `in_data_i` in 32: record word.
- `flush_i` in 1: abandon the partial record and return to header state.
- RVFI outputs:
  - `rvfi_valid` out 1: one-cycle retirement pulse.
  - `rvfi_order` out 64: retirement sequence number.
  - `rvfi_insn`, `rvfi_pc_rdata`, `rvfi_pc_wdata` out 32 each: instruction word, PC, next PC.
  - `rvfi_trap`, `rvfi_halt`, `rvfi_intr` out 1 each: header flags.
  - `rvfi_mode` out 2: privilege mode.
  - `rvfi_ixl` out 2: constant 2'b01.
  - `rvfi_rs1_addr`, `rvfi_rs2_addr`, `rvfi_rd_addr` out 5 each: register addresses.
  - `rvfi_rs1_rdata`, `rvfi_rs2_rdata`, `rvfi_rd_wdata` out 32 each: register data.
  - `rvfi_mem_addr`, `rvfi_mem_rdata`, `rvfi_mem_wdata` out 32 each: memory access.
  - `rvfi_mem_rmask`, `rvfi_mem_wmask` out 4 each: byte masks.
- `err_o` out 1: sticky malformed-record flag; cleared only by reset.

## Operation
- Record format: word 0 is the header. The body words follow in this order:
  1. insn
  2. pc_rdata
  3. pc_wdata
  4. rs1_rdata
  5. rs2_rdata
  6. rd_wdata
  7. mem_addr, mem_rdata, mem_wdata, present only if has_mem is set.
- Record length: 7 words without memory fields, 10 words with them.
- Header bit fields:
  - [0] trap, [1] halt, [2] intr.
  - [4:3] mode.
  - [9:5] rd_addr, [14:10] rs1_addr, [19:15] rs2_addr.
  - [20] has_mem.
  - [24:21] rmask, [28:25] wmask.
  - [31:29] reserved.
- FSM states:
  - HDR: waiting for a header word.
  - BODY: collecting body words.
  - HDR→BODY on header acceptance. The header is latched and word index `widx` (4 bits) is cleared to 0.
  - BODY: each accepted word is stored at `widx`, then `widx` increments.
  - BODY→HDR on the last word: `widx`==5 without memory fields, `widx`==8 with them.
  - Any state→HDR on `flush_i`, which also clears `widx`.
- Emit: on last-word acceptance, the shadow fields plus the last word are copied into the output registers and `rvfi_valid` pulses for the next cycle.
  - `rvfi_order` takes the running counter, which then increments by 1 and wraps at 2^64.
- Output stability: output registers hold their values until the next emit.
- Dropped records: the record is consumed fully (length still taken from has_mem) but produces no pulse and no order increment. A record is dropped when either:
  - `StrictHeader`=1 and header[31:29]≠0, or
  - has_mem=1 while memory support is compiled out (see Configuration).
- Dropped records set `err_o`.
- Normalisation on emit:
  - rd_addr==0 forces `rvfi_rd_wdata`=0.
  - has_mem=0 forces all `rvfi_mem_*`=0.
- `in_ready_o` = ~`rst_i` & ~`flush_i`.

## Timing
- Reset values:
  - All outputs 0 except `rvfi_ixl`=2'b01.
  - `in_ready_o`=0 while `rst_i` is high.
  - FSM in HDR; order counter loaded with `OrderInit`.
- Latency: `rvfi_valid` asserts exactly 1 cycle after the last word of a record is accepted, for 1 cycle.
- Throughput: one word per cycle with no bubbles. The header of the next record may be accepted in the same cycle that `rvfi_valid` is high.
- Flush vs. input word in the same cycle: flush wins and the word is not accepted.
- Flush in the cycle `rvfi_valid` is high: the pulse still completes; only a partial record is discarded.
- Reset mid-record: the partial record is lost, no pulse is emitted, and `err_o` is cleared.
- `in_valid_i` low: the FSM holds state with no timeout.

## Configuration
- `IBEX_RVFI_UNPACK_MEM_EN` defined:
  - has_mem records are accepted.
  - The three mem words are decoded and the mask fields are driven out.
- `IBEX_RVFI_UNPACK_MEM_EN` undefined:
  - The mem shadow registers are removed and all `rvfi_mem_*` are tied to 0.
  - A header with has_mem=1 is dropped with `err_o`. Its 10 words are still consumed so the stream stays aligned.

## Structure
- `ibex_pkg` gains:
  - `rvfi_rec_hdr_t` packed struct for the header layout.
  - Constants `RVFI_REC_BASE_WORDS`=7 and `RVFI_REC_MEM_WORDS`=3.
- One sub-module, `ibex_rvfi_rec_hdr_dec`: combinational header unpack plus reserved-bit check. Its outputs are the field struct, a record-length value and a malformed flag.
- Everything else (FSM, shadow registers, order counter) lives flat in `ibex_rvfi_unpacker`.

## Test plan
- Non-memory record: header 32'h0000_00A8 (rd=5) followed by words 1..6 with values 32'h0000_0013, 32'h100, 32'h104, 1, 2, 3 → exactly 1 cycle later `rvfi_valid`=1, `rvfi_order`=0, `rvfi_rd_addr`=5, `rvfi_rd_wdata`=3, `rvfi_pc_wdata`=32'h104, `rvfi_mem_*`=0.
- Memory record with the macro defined: header with has_mem=1 and rmask=4'hF, then mem words 32'h2000/32'hDEAD/0 → `rvfi_mem_addr`=32'h2000, `rvfi_mem_rdata`=32'hDEAD, `rvfi_mem_rmask`=4'hF; 10 words consumed.
- Back-to-back records, each with rd=0 and rd_wdata=32'hFFFF: `in_valid_i` held high → valid pulses every 7 cycles, `rvfi_order` 0,1,2, `rvfi_rd_wdata`=0 on every pulse, no stall.
- Malformed record: header 32'hE000_0000 with `StrictHeader`=1 → 7 words consumed, no pulse, `err_o`=1 and stays 1. The following good record is emitted with `rvfi_order`=0.
- Flush after 3 body words, then a complete record → exactly one pulse, carrying the second record's values.
- Reset: `rst_i` high 1 cycle in the middle of a record → `err_o`=0, `in_ready_o`=0 during reset. The next complete record is emitted with `rvfi_order`=`OrderInit`.

Source files
------------

// File: rtl/ibex_pkg.sv
// Shared trace-record definitions: header layout, record sizes, unpacker FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ibex_pkg;

    // Body words always present, plus the optional memory-access words.
    localparam int unsigned RVFI_REC_BASE_WORDS = 7;
    localparam int unsigned RVFI_REC_MEM_WORDS  = 3;

    // Header word layout, MSB first.
    typedef struct packed {
        logic [2:0] rsvd;
        logic [3:0] wmask;
        logic [3:0] rmask;
        logic       has_mem;
        logic [4:0] rs2_addr;
        logic [4:0] rs1_addr;
        logic [4:0] rd_addr;
        logic [1:0] mode;
        logic       intr;
        logic       halt;
        logic       trap;
    } rvfi_rec_hdr_t;

    typedef enum logic {
        UNP_HDR  = 1'b0,
        UNP_BODY = 1'b1
    } unp_state_e;

    // Total record length in words, header included.
    function automatic logic [3:0] rvfi_rec_len(input logic has_mem);
        return has_mem ? 4'(RVFI_REC_BASE_WORDS + RVFI_REC_MEM_WORDS)
                       : 4'(RVFI_REC_BASE_WORDS);
    endfunction

endpackage

// File: rtl/ibex_rvfi_rec_hdr_dec.sv
// Header word decoder: field unpack, record length, malformed flag (IBEX_RVFI_UNPACK_MEM_EN).
// Latency: purely combinational.
// Backpressure: none; evaluated on whatever word is presented.
module ibex_rvfi_rec_hdr_dec
    import ibex_pkg::*;
#(
    parameter bit StrictHeader = 1'b1
) (
    input  logic [31:0]   word_i,
    output rvfi_rec_hdr_t hdr_o,
    output logic [3:0]    rec_len_o,
    output logic          malformed_o
);

    logic rsvd_bad;
    logic mem_bad;

    // Unpack the header and flag records that must be consumed but not emitted.
    always_comb begin
        hdr_o     = rvfi_rec_hdr_t'(word_i);
        rec_len_o = rvfi_rec_len(hdr_o.has_mem);
        rsvd_bad  = StrictHeader && (hdr_o.rsvd != 3'b000);
`ifdef IBEX_RVFI_UNPACK_MEM_EN
        mem_bad   = 1'b0;
`else
        // Memory fields cannot be represented in this build.
        mem_bad   = hdr_o.has_mem;
`endif
        malformed_o = rsvd_bad | mem_bad;
    end

endmodule

// File: rtl/ibex_rvfi_unpacker.sv
// Rebuilds RVFI retirements from a 32-bit word stream of packed records (IBEX_RVFI_UNPACK_MEM_EN adds mem fields).
// Latency: rvfi_valid pulses 1 cycle after the last word of a record is accepted.
// Backpressure: accepts one word per cycle; in_ready_o drops only during reset or flush.
module ibex_rvfi_unpacker
    import ibex_pkg::*;
#(
    parameter logic [63:0] OrderInit    = 64'd0,
    parameter bit          StrictHeader = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [31:0] in_data_i,
    input  logic        flush_i,
    output logic        rvfi_valid,
    output logic [63:0] rvfi_order,
    output logic [31:0] rvfi_insn,
    output logic [31:0] rvfi_pc_rdata,
    output logic [31:0] rvfi_pc_wdata,
    output logic        rvfi_trap,
    output logic        rvfi_halt,
    output logic        rvfi_intr,
    output logic [1:0]  rvfi_mode,
    output logic [1:0]  rvfi_ixl,
    output logic [4:0]  rvfi_rs1_addr,
    output logic [4:0]  rvfi_rs2_addr,
    output logic [4:0]  rvfi_rd_addr,
    output logic [31:0] rvfi_rs1_rdata,
    output logic [31:0] rvfi_rs2_rdata,
    output logic [31:0] rvfi_rd_wdata,
    output logic [31:0] rvfi_mem_addr,
    output logic [31:0] rvfi_mem_rdata,
    output logic [31:0] rvfi_mem_wdata,
    output logic [3:0]  rvfi_mem_rmask,
    output logic [3:0]  rvfi_mem_wmask,
    output logic        err_o
);

    unp_state_e    state_q, state_d;
    logic [3:0]    widx_q;
    logic [3:0]    last_idx_q;
    rvfi_rec_hdr_t hdr_q;
    logic          drop_q;
    logic [63:0]   order_q;

    logic [31:0]   insn_q, pc_rdata_q, pc_wdata_q, rs1_rdata_q, rs2_rdata_q;
    logic [31:0]   rd_wdata_src;

    rvfi_rec_hdr_t dec_hdr;
    logic [3:0]    dec_len;
    logic          dec_bad;

    logic          word_acc, hdr_acc, body_acc, last_acc, emit;

    ibex_rvfi_rec_hdr_dec #(
        .StrictHeader(StrictHeader)
    ) u_hdr_dec (
        .word_i     (in_data_i),
        .hdr_o      (dec_hdr),
        .rec_len_o  (dec_len),
        .malformed_o(dec_bad)
    );

    assign rvfi_ixl = 2'b01;

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= UNP_HDR;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: flush always returns to header hunting.
    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = UNP_HDR;
        end else if (hdr_acc) begin
            state_d = UNP_BODY;
        end else if (last_acc) begin
            state_d = UNP_HDR;
        end
    end

    // Handshake and transfer strobes; a flushed word is never accepted.
    always_comb begin
        in_ready_o = ~rst_i & ~flush_i;
        word_acc   = in_valid_i & in_ready_o;
        hdr_acc    = (state_q == UNP_HDR) & word_acc;
        body_acc   = (state_q == UNP_BODY) & word_acc;
        last_acc   = body_acc & (widx_q == last_idx_q);
        emit       = last_acc & ~drop_q;
    end

    // Record bookkeeping: latched header, word index, drop decision, sticky error.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            widx_q     <= 4'd0;
            last_idx_q <= 4'(RVFI_REC_BASE_WORDS - 2);
            hdr_q      <= '0;
            drop_q     <= 1'b0;
            err_o      <= 1'b0;
        end else if (flush_i) begin
            widx_q <= 4'd0;
        end else if (hdr_acc) begin
            hdr_q      <= dec_hdr;
            drop_q     <= dec_bad;
            // Body words are indexed from 0, so the last one sits two below the length.
            last_idx_q <= dec_len - 4'd2;
            widx_q     <= 4'd0;
            if (dec_bad) begin
                err_o <= 1'b1;
            end
        end else if (body_acc) begin
            widx_q <= widx_q + 4'd1;
        end
    end

    // Body word shadows for fields that arrive before the last word.
    always_ff @(posedge clk_i) begin
        if (body_acc) begin
            case (widx_q)
                4'd0: insn_q      <= in_data_i;
                4'd1: pc_rdata_q  <= in_data_i;
                4'd2: pc_wdata_q  <= in_data_i;
                4'd3: rs1_rdata_q <= in_data_i;
                4'd4: rs2_rdata_q <= in_data_i;
                default: ;
            endcase
        end
    end

`ifdef IBEX_RVFI_UNPACK_MEM_EN
    logic [31:0] rd_wdata_q, mem_addr_q, mem_rdata_q;
    logic [2:0]  unused_hdr_bits;

    assign unused_hdr_bits = hdr_q.rsvd;

    // Extra shadows for mem-bearing records, where rd_wdata is no longer the last word.
    always_ff @(posedge clk_i) begin
        if (body_acc) begin
            case (widx_q)
                4'd5: rd_wdata_q  <= in_data_i;
                4'd6: mem_addr_q  <= in_data_i;
                4'd7: mem_rdata_q <= in_data_i;
                default: ;
            endcase
        end
    end

    assign rd_wdata_src = hdr_q.has_mem ? rd_wdata_q : in_data_i;

    // Memory outputs: loaded on emit, zeroed for records without memory fields.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rvfi_mem_addr  <= 32'd0;
            rvfi_mem_rdata <= 32'd0;
            rvfi_mem_wdata <= 32'd0;
            rvfi_mem_rmask <= 4'd0;
            rvfi_mem_wmask <= 4'd0;
        end else if (emit) begin
            if (hdr_q.has_mem) begin
                rvfi_mem_addr  <= mem_addr_q;
                rvfi_mem_rdata <= mem_rdata_q;
                rvfi_mem_wdata <= in_data_i;
                rvfi_mem_rmask <= hdr_q.rmask;
                rvfi_mem_wmask <= hdr_q.wmask;
            end else begin
                rvfi_mem_addr  <= 32'd0;
                rvfi_mem_rdata <= 32'd0;
                rvfi_mem_wdata <= 32'd0;
                rvfi_mem_rmask <= 4'd0;
                rvfi_mem_wmask <= 4'd0;
            end
        end
    end
`else
    logic unused_hdr_bits;

    // has_mem records are always dropped here, so rd_wdata is always the last word.
    assign unused_hdr_bits = ^{hdr_q.rsvd, hdr_q.wmask, hdr_q.rmask, hdr_q.has_mem};
    assign rd_wdata_src    = in_data_i;

    assign rvfi_mem_addr  = 32'd0;
    assign rvfi_mem_rdata = 32'd0;
    assign rvfi_mem_wdata = 32'd0;
    assign rvfi_mem_rmask = 4'd0;
    assign rvfi_mem_wmask = 4'd0;
`endif

    // Retirement outputs and order counter: updated only on emit, held otherwise.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rvfi_valid     <= 1'b0;
            order_q        <= OrderInit;
            rvfi_order     <= 64'd0;
            rvfi_insn      <= 32'd0;
            rvfi_pc_rdata  <= 32'd0;
            rvfi_pc_wdata  <= 32'd0;
            rvfi_trap      <= 1'b0;
            rvfi_halt      <= 1'b0;
            rvfi_intr      <= 1'b0;
            rvfi_mode      <= 2'd0;
            rvfi_rs1_addr  <= 5'd0;
            rvfi_rs2_addr  <= 5'd0;
            rvfi_rd_addr   <= 5'd0;
            rvfi_rs1_rdata <= 32'd0;
            rvfi_rs2_rdata <= 32'd0;
            rvfi_rd_wdata  <= 32'd0;
        end else begin
            rvfi_valid <= emit;
            if (emit) begin
                order_q        <= order_q + 64'd1;
                rvfi_order     <= order_q;
                rvfi_insn      <= insn_q;
                rvfi_pc_rdata  <= pc_rdata_q;
                rvfi_pc_wdata  <= pc_wdata_q;
                rvfi_trap      <= hdr_q.trap;
                rvfi_halt      <= hdr_q.halt;
                rvfi_intr      <= hdr_q.intr;
                rvfi_mode      <= hdr_q.mode;
                rvfi_rs1_addr  <= hdr_q.rs1_addr;
                rvfi_rs2_addr  <= hdr_q.rs2_addr;
                rvfi_rd_addr   <= hdr_q.rd_addr;
                rvfi_rs1_rdata <= rs1_rdata_q;
                rvfi_rs2_rdata <= rs2_rdata_q;
                // x0 writes are architecturally invisible.
                rvfi_rd_wdata  <= (hdr_q.rd_addr == 5'd0) ? 32'd0 : rd_wdata_src;
            end
        end
    end

endmodule

// File: tb/tb_ibex_rvfi_unpacker.sv
// Directed bench for the RVFI record unpacker: vector table plus corner-case sequences.
// Latency: checks the pulse lands exactly one cycle after the last word.
// Backpressure: drives words every cycle; flush and reset exercise ready deassertion.
module tb_ibex_rvfi_unpacker;

    logic        clk_i = 1'b0;
    logic        rst_i, in_valid_i, flush_i;
    logic [31:0] in_data_i;
    logic        in_ready_o, rvfi_valid, rvfi_trap, rvfi_halt, rvfi_intr, err_o;
    logic [63:0] rvfi_order;
    logic [31:0] rvfi_insn, rvfi_pc_rdata, rvfi_pc_wdata;
    logic [1:0]  rvfi_mode, rvfi_ixl;
    logic [4:0]  rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr;
    logic [31:0] rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rd_wdata;
    logic [31:0] rvfi_mem_addr, rvfi_mem_rdata, rvfi_mem_wdata;
    logic [3:0]  rvfi_mem_rmask, rvfi_mem_wmask;

`ifdef IBEX_RVFI_UNPACK_MEM_EN
    localparam bit MEM = 1'b1;
`else
    localparam bit MEM = 1'b0;
`endif

    ibex_rvfi_unpacker #(
        .OrderInit   (64'd0),
        .StrictHeader(1'b1)
    ) dut (
        .clk_i, .rst_i, .in_valid_i, .in_ready_o, .in_data_i, .flush_i,
        .rvfi_valid, .rvfi_order, .rvfi_insn, .rvfi_pc_rdata, .rvfi_pc_wdata,
        .rvfi_trap, .rvfi_halt, .rvfi_intr, .rvfi_mode, .rvfi_ixl,
        .rvfi_rs1_addr, .rvfi_rs2_addr, .rvfi_rd_addr,
        .rvfi_rs1_rdata, .rvfi_rs2_rdata, .rvfi_rd_wdata,
        .rvfi_mem_addr, .rvfi_mem_rdata, .rvfi_mem_wdata,
        .rvfi_mem_rmask, .rvfi_mem_wmask, .err_o
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        int          stamp;
        logic [63:0] order;
        logic [31:0] insn, pc_w, rd_wdata, mem_addr, mem_rdata;
        logic [4:0]  rd;
        logic [3:0]  rmask;
        logic [2:0]  flags;
        logic [1:0]  mode;
    } pulse_t;

    pulse_t mq[$];

    // Capture every retirement pulse mid-cycle.
    always @(negedge clk_i) begin : mon
        pulse_t p;
        if (rvfi_valid === 1'b1) begin
            p.stamp     = cyc;
            p.order     = rvfi_order;
            p.insn      = rvfi_insn;
            p.pc_w      = rvfi_pc_wdata;
            p.rd_wdata  = rvfi_rd_wdata;
            p.mem_addr  = rvfi_mem_addr;
            p.mem_rdata = rvfi_mem_rdata;
            p.rd        = rvfi_rd_addr;
            p.rmask     = rvfi_mem_rmask;
            p.flags     = {rvfi_intr, rvfi_halt, rvfi_trap};
            p.mode      = rvfi_mode;
            mq.push_back(p);
        end
    end

    int nvec = 0;
    int nmis = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef logic [8:0][31:0] body_t;

    function automatic body_t mkb(input logic [31:0] b0, b1, b2, b3, b4, b5,
                                  input logic [31:0] b6 = 32'd0, b7 = 32'd0, b8 = 32'd0);
        body_t b;
        b[0] = b0; b[1] = b1; b[2] = b2; b[3] = b3; b[4] = b4;
        b[5] = b5; b[6] = b6; b[7] = b7; b[8] = b8;
        return b;
    endfunction

    typedef struct {
        logic [31:0] hdr;
        body_t       body;
        int          nbody;
        bit          emit;
        logic [31:0] insn, pc_w, rd_wdata, mem_addr, mem_rdata;
        logic [4:0]  rd;
        logic [3:0]  rmask;
        logic [2:0]  flags;
        logic [1:0]  mode;
    } vec_t;

    vec_t vecs[8];
    int   ls[8];

    task automatic put(input logic [31:0] w);
        in_valid_i = 1'b1;
        in_data_i  = w;
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid_i = 1'b0;
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic send_rec(input logic [31:0] hdr, input body_t b, input int nb, output int stamp);
        put(hdr);
        for (int i = 0; i < nb; i++) put(b[i]);
        stamp = cyc;
    endtask

    pulse_t      p;
    int          s;
    logic [63:0] exp_order;

    initial begin
        rst_i = 1'b1; in_valid_i = 1'b0; flush_i = 1'b0; in_data_i = 32'd0;

        vecs[0] = '{hdr:32'h0000_00A8, body:mkb(32'h13, 32'h100, 32'h104, 1, 2, 3), nbody:6, emit:1'b1,
                    insn:32'h13, pc_w:32'h104, rd_wdata:32'd3, mem_addr:0, mem_rdata:0,
                    rd:5'd5, rmask:4'h0, flags:3'b000, mode:2'd1};
        vecs[1] = '{hdr:32'h0000_0007, body:mkb(32'h33, 32'h104, 32'h108, 4, 5, 32'hFFFF), nbody:6, emit:1'b1,
                    insn:32'h33, pc_w:32'h108, rd_wdata:32'd0, mem_addr:0, mem_rdata:0,
                    rd:5'd0, rmask:4'h0, flags:3'b111, mode:2'd0};
        vecs[2] = '{hdr:32'h0000_0000, body:mkb(32'h73, 32'h108, 32'h10C, 0, 0, 32'hFFFF), nbody:6, emit:1'b1,
                    insn:32'h73, pc_w:32'h10C, rd_wdata:32'd0, mem_addr:0, mem_rdata:0,
                    rd:5'd0, rmask:4'h0, flags:3'b000, mode:2'd0};
        vecs[3] = '{hdr:32'h0000_0010, body:mkb(32'h93, 32'h10C, 32'h110, 0, 0, 32'hFFFF), nbody:6, emit:1'b1,
                    insn:32'h93, pc_w:32'h110, rd_wdata:32'd0, mem_addr:0, mem_rdata:0,
                    rd:5'd0, rmask:4'h0, flags:3'b000, mode:2'd2};
        vecs[4] = '{hdr:32'hE000_0000, body:mkb(32'h0000_00A8, 32'h1, 32'h2, 32'h3, 32'h4, 32'h5), nbody:6, emit:1'b0,
                    insn:0, pc_w:0, rd_wdata:0, mem_addr:0, mem_rdata:0,
                    rd:5'd0, rmask:4'h0, flags:3'b000, mode:2'd0};
        vecs[5] = '{hdr:32'h0000_03E0, body:mkb(32'hB3, 32'h110, 32'h114, 9, 9, 32'h1234), nbody:6, emit:1'b1,
                    insn:32'hB3, pc_w:32'h114, rd_wdata:32'h1234, mem_addr:0, mem_rdata:0,
                    rd:5'd31, rmask:4'h0, flags:3'b000, mode:2'd0};
        vecs[6] = '{hdr:32'h01F0_00A0,
                    body:mkb(32'h23, 32'h200, 32'h204, 1, 2, 32'h77, 32'h2000, 32'hDEAD, 32'h0),
                    nbody:9, emit:MEM,
                    insn:32'h23, pc_w:32'h204, rd_wdata:32'h77, mem_addr:32'h2000, mem_rdata:32'hDEAD,
                    rd:5'd5, rmask:4'hF, flags:3'b000, mode:2'd0};
        vecs[7] = '{hdr:32'h0000_0041, body:mkb(32'hC3, 32'h300, 32'h304, 0, 0, 32'h55), nbody:6, emit:1'b1,
                    insn:32'hC3, pc_w:32'h304, rd_wdata:32'h55, mem_addr:0, mem_rdata:0,
                    rd:5'd2, rmask:4'h0, flags:3'b001, mode:2'd0};

        // Reset state.
        @(posedge clk_i); #1;
        chk("rst_in_ready", in_ready_o, 0);
        @(posedge clk_i); #1;
        chk("rst_valid", rvfi_valid, 0);
        chk("rst_ixl", rvfi_ixl, 2'b01);
        chk("rst_err", err_o, 0);
        chk("rst_order", rvfi_order, 0);
        chk("rst_insn", rvfi_insn, 0);
        chk("rst_mem_addr", rvfi_mem_addr, 0);
        rst_i = 1'b0;
        #1;
        chk("in_ready_idle", in_ready_o, 1);

        // Table: all records streamed back-to-back with in_valid held high.
        for (int v = 0; v < 8; v++) send_rec(vecs[v].hdr, vecs[v].body, vecs[v].nbody, ls[v]);
        idle(2);

        exp_order = 64'd0;
        for (int v = 0; v < 8; v++) begin
            if (vecs[v].emit) begin
                if (mq.size() == 0) begin
                    chk($sformatf("v%0d_pulse_present", v), 0, 1);
                end else begin
                    p = mq.pop_front();
                    chk($sformatf("v%0d_order", v), p.order, exp_order);
                    chk($sformatf("v%0d_latency", v), p.stamp, ls[v]);
                    chk($sformatf("v%0d_insn", v), p.insn, vecs[v].insn);
                    chk($sformatf("v%0d_pc_wdata", v), p.pc_w, vecs[v].pc_w);
                    chk($sformatf("v%0d_rd_addr", v), p.rd, vecs[v].rd);
                    chk($sformatf("v%0d_rd_wdata", v), p.rd_wdata, vecs[v].rd_wdata);
                    chk($sformatf("v%0d_mem_addr", v), p.mem_addr, vecs[v].mem_addr);
                    chk($sformatf("v%0d_mem_rdata", v), p.mem_rdata, vecs[v].mem_rdata);
                    chk($sformatf("v%0d_rmask", v), p.rmask, vecs[v].rmask);
                    chk($sformatf("v%0d_flags", v), p.flags, vecs[v].flags);
                    chk($sformatf("v%0d_mode", v), p.mode, vecs[v].mode);
                end
                exp_order++;
            end
        end
        chk("table_extra_pulses", mq.size(), 0);
        chk("table_err_sticky", err_o, 1);

        // Reset in the middle of a record: partial record lost, error cleared.
        mq.delete();
        put(vecs[0].hdr);
        for (int i = 0; i < 3; i++) put(vecs[0].body[i]);
        rst_i = 1'b1;
        in_data_i = 32'h1234_5678;
        #1;
        chk("midrst_in_ready", in_ready_o, 0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        chk("midrst_err", err_o, 0);
        chk("midrst_valid", rvfi_valid, 0);

        // Malformed header, then a good record that must get the initial order.
        send_rec(32'hE000_0000, mkb(1, 2, 3, 4, 5, 6), 6, s);
        chk("bad_err_set", err_o, 1);
        send_rec(vecs[0].hdr, vecs[0].body, 6, s);
        idle(2);
        chk("bad_pulse_count", mq.size(), 1);
        if (mq.size() != 0) begin
            p = mq.pop_front();
            chk("bad_next_order", p.order, 0);
            chk("bad_next_rd_wdata", p.rd_wdata, 3);
            chk("bad_next_latency", p.stamp, s);
        end
        chk("bad_err_stays", err_o, 1);

        // Flush after 3 body words with a competing word, then a record with a bubble.
        mq.delete();
        put(vecs[1].hdr);
        for (int i = 0; i < 3; i++) put(vecs[1].body[i]);
        flush_i = 1'b1;
        in_valid_i = 1'b1;
        in_data_i = vecs[7].hdr;
        #1;
        chk("flush_in_ready", in_ready_o, 0);
        @(posedge clk_i); #1;
        flush_i = 1'b0;
        put(vecs[7].hdr);
        put(vecs[7].body[0]);
        put(vecs[7].body[1]);
        idle(2);
        for (int i = 2; i < 6; i++) put(vecs[7].body[i]);
        s = cyc;
        // Flush while the pulse is high must not cancel it.
        flush_i = 1'b1;
        in_valid_i = 1'b0;
        #1;
        chk("flush_during_pulse", rvfi_valid, 1);
        @(posedge clk_i); #1;
        flush_i = 1'b0;
        idle(3);
        chk("flush_pulse_count", mq.size(), 1);
        if (mq.size() != 0) begin
            p = mq.pop_front();
            chk("flush_order", p.order, 1);
            chk("flush_insn", p.insn, 32'hC3);
            chk("flush_rd_wdata", p.rd_wdata, 32'h55);
            chk("flush_latency", p.stamp, s);
        end

        // Outputs hold after the pulse.
        chk("hold_valid", rvfi_valid, 0);
        chk("hold_insn", rvfi_insn, 32'hC3);
        chk("hold_order", rvfi_order, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
